// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control handshakes, shared memory read data, debug step pins and decoded outputs.
// Latency: none (wires only).
// Backpressure: the control side throttles the fetch stage through pc_en and insdat.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            pc_en;
    logic            jump;
    logic            branch;
    logic            insdat;
    logic [15:0]     mem_rdata;
    logic            step_mode;
    logic            step_exe;
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
    logic [4:0]      opcode;
    logic [2:0]      rdest;
    logic [2:0]      rsrc1;
    logic [2:0]      rsrc2;
    logic [2:0]      func;
    logic            rdestBit0;
    logic            halted;
    logic            step_wait;
    logic [15:0]     retired;

    modport master (
        output pc_en, jump, branch, insdat, mem_rdata, step_mode, step_exe,
        input  pc, instr, opcode, rdest, rsrc1, rsrc2, func, rdestBit0,
               halted, step_wait, retired
    );

    modport slave (
        input  pc_en, jump, branch, insdat, mem_rdata, step_mode, step_exe,
        output pc, instr, opcode, rdest, rsrc1, rsrc2, func, rdestBit0,
               halted, step_wait, retired
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures/holds the instruction word, decodes fields, applies redirects and step gating.
// Latency: PC, halt flag and retire count update one cycle after an advance; instr/decode are combinational.
// Backpressure: the PC holds while pc_en is low, after a halt, or in single-step mode with no step token pending.
module fetch_unit #(
    parameter int PC_W = 8
) (
    input logic         clock,
    input logic         reset_n,
    fetch_unit_if.slave bus
);
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic            halted_q;
    logic            step_tok;
    logic [15:0]     retired_q;
    logic            sync1;
    logic            sync2;
    logic            sync3;

    logic [15:0]     instr;
    logic            step_edge;
    logic            advance;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_next;

    // During the data cycle of a two-cycle op the memory port carries data, so the held word is used instead.
    assign instr     = bus.insdat ? ir_q : bus.mem_rdata;
    assign step_edge = sync2 & ~sync3;
    assign advance   = bus.pc_en & ~halted_q & (~bus.step_mode | step_tok);
    assign br_off    = PC_W'({{PC_W{instr[7]}}, instr[7:0]});

    // Next PC: jump beats branch, branch beats sequential; wraps naturally at PC_W bits.
    always_comb begin
        pc_next = pc_q + PC_W'(1);
        if (bus.jump) begin
            pc_next = instr[PC_W-1:0];
        end else if (bus.branch) begin
            pc_next = pc_q + PC_W'(1) + br_off;
        end
    end

    // Synchronise the asynchronous step pin and keep one extra stage for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.step_exe;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Step token: a new edge wins over consumption so back-to-back steps are never lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_tok <= 1'b0;
        end else if (step_edge) begin
            step_tok <= 1'b1;
        end else if (advance) begin
            step_tok <= 1'b0;
        end
    end

    // PC, instruction register, sticky halt and retire counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            if (!bus.insdat) begin
                ir_q <= bus.mem_rdata;
                if (bus.mem_rdata[15:11] == 5'b11111) begin
                    halted_q <= 1'b1;
                end
            end
            if (advance) begin
                pc_q      <= pc_next;
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.instr     = instr;
    assign bus.opcode    = instr[15:11];
    assign bus.rdest     = instr[10:8];
    assign bus.rsrc1     = instr[7:5];
    assign bus.rsrc2     = instr[4:2];
    assign bus.func      = {1'b0, instr[1:0]};
    assign bus.rdestBit0 = instr[8];
    assign bus.halted    = halted_q;
    assign bus.step_wait = bus.step_mode & ~step_tok;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and per-cycle comparison.
// Latency: model state updates on the same edges as the design; outputs compared mid-low-phase.
// Backpressure: stimulus drives pc_en/insdat/step pins directly; every wait is a fixed cycle count.
module tb_fetch_unit;
    localparam int PW   = 8;
    localparam int MASK = (1 << PW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_unit_if #(.PC_W(PW)) bus ();

    fetch_unit #(.PC_W(PW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model state: architectural view of the fetch stage.
    int m_pc, m_ir, m_halt, m_ret, m_tok;
    int m_lvl [3];  // step pin level sampled 1, 2 and 3 edges ago

    function automatic int cur_instr();
        return bus.insdat ? m_ir : int'(bus.mem_rdata);
    endfunction

    function automatic int may_advance();
        return (bus.pc_en && m_halt == 0 && (!bus.step_mode || m_tok != 0)) ? 1 : 0;
    endfunction

    function automatic int target_pc();
        int ins, off;
        ins = cur_instr();
        off = ins & 'hFF;
        if (off >= 128) off = off - 256;
        if (bus.jump)   return ins & MASK;
        if (bus.branch) return (m_pc + 1 + off) & MASK;
        return (m_pc + 1) & MASK;
    endfunction

    // Model update on every edge using the inputs held stable since the previous falling edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pc <= 0; m_ir <= 0; m_halt <= 0; m_ret <= 0; m_tok <= 0;
            m_lvl[0] <= 0; m_lvl[1] <= 0; m_lvl[2] <= 0;
        end else begin
            if (may_advance() != 0) begin
                m_pc  <= target_pc();
                m_ret <= (m_ret + 1) & 'hFFFF;
            end
            if (m_lvl[1] == 1 && m_lvl[2] == 0) m_tok <= 1;
            else if (may_advance() != 0)        m_tok <= 0;
            if (!bus.insdat) begin
                m_ir <= int'(bus.mem_rdata);
                if (bus.mem_rdata[15:11] == 5'b11111) m_halt <= 1;
            end
            m_lvl[0] <= int'(bus.step_exe);
            m_lvl[1] <= m_lvl[0];
            m_lvl[2] <= m_lvl[1];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        int ins;
        #2;
        ins = cur_instr();
        chk("pc",        int'(bus.pc),        m_pc);
        chk("instr",     int'(bus.instr),     ins);
        chk("opcode",    int'(bus.opcode),    (ins >> 11) & 'h1F);
        chk("rdest",     int'(bus.rdest),     (ins >> 8) & 7);
        chk("rsrc1",     int'(bus.rsrc1),     (ins >> 5) & 7);
        chk("rsrc2",     int'(bus.rsrc2),     (ins >> 2) & 7);
        chk("func",      int'(bus.func),      ins & 3);
        chk("rdestBit0", int'(bus.rdestBit0), (ins >> 8) & 1);
        chk("halted",    int'(bus.halted),    m_halt);
        chk("step_wait", int'(bus.step_wait), (bus.step_mode && m_tok == 0) ? 1 : 0);
        chk("retired",   int'(bus.retired),   m_ret);
    end

    task automatic next();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.pc_en = 1'b0; bus.jump = 1'b0; bus.branch = 1'b0;
        bus.insdat = 1'b0; bus.mem_rdata = 16'h0000; bus.step_exe = 1'b0;
    endtask

    task automatic do_reset();
        next();
        reset_n = 1'b0;
        idle_inputs();
        #3;
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_retired", int'(bus.retired), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_step_wait", int'(bus.step_wait), int'(bus.step_mode));
        next();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus.step_mode = 1'b0;
        #1 reset_n = 1'b0;
        next();
        do_reset();

        // Sequential run with NOP words: 260 advances wrap the 8-bit PC.
        bus.pc_en = 1'b1;
        for (int i = 0; i < 260; i++) next();
        bus.pc_en = 1'b0;
        #3;
        chk("seq_pc", int'(bus.pc), 4);
        chk("seq_retired", int'(bus.retired), 260);

        // Jump from 0x10.
        do_reset();
        bus.pc_en = 1'b1;
        for (int i = 0; i < 16; i++) next();
        #3 chk("pre_jump_pc", int'(bus.pc), 'h10);
        bus.jump = 1'b1; bus.mem_rdata = 16'hC02A;
        next();
        bus.jump = 1'b0; bus.mem_rdata = 16'h0000; bus.pc_en = 1'b0;
        #3 chk("jump_pc", int'(bus.pc), 'h2A);

        // Backward branch from 0x05 wraps.
        do_reset();
        bus.pc_en = 1'b1;
        for (int i = 0; i < 5; i++) next();
        bus.branch = 1'b1; bus.mem_rdata = 16'h00F0;
        next();
        bus.branch = 1'b0; bus.mem_rdata = 16'h0000; bus.pc_en = 1'b0;
        #3 chk("branch_pc", int'(bus.pc), 'hF6);

        // Jump and branch together: jump target taken.
        bus.pc_en = 1'b1; bus.jump = 1'b1; bus.branch = 1'b1; bus.mem_rdata = 16'h0033;
        next();
        bus.pc_en = 1'b0; bus.jump = 1'b0; bus.branch = 1'b0; bus.mem_rdata = 16'h0000;
        #3 chk("jump_vs_branch_pc", int'(bus.pc), 'h33);

        // Two-cycle op: instruction held while the port returns data.
        do_reset();
        bus.insdat = 1'b0; bus.pc_en = 1'b0; bus.mem_rdata = 16'h1234;
        next();
        bus.insdat = 1'b1; bus.pc_en = 1'b1; bus.mem_rdata = 16'hBEEF;
        #3;
        chk("hold_instr", int'(bus.instr), 'h1234);
        chk("hold_rdest", int'(bus.rdest), 2);
        next();
        bus.insdat = 1'b0; bus.pc_en = 1'b0; bus.mem_rdata = 16'h0000;
        #3 chk("hold_pc", int'(bus.pc), 1);

        // Halt freezes PC and retire count until reset.
        do_reset();
        bus.pc_en = 1'b1;
        for (int i = 0; i < 3; i++) next();
        bus.pc_en = 1'b0; bus.mem_rdata = 16'hF800;
        next();
        bus.mem_rdata = 16'h0000; bus.pc_en = 1'b1;
        #3 chk("halt_set", int'(bus.halted), 1);
        for (int i = 0; i < 20; i++) next();
        #3;
        chk("halt_pc", int'(bus.pc), 3);
        chk("halt_retired", int'(bus.retired), 3);
        bus.step_mode = 1'b1;
        do_reset();
        #3;
        chk("halt_cleared", int'(bus.halted), 0);

        // Single-step: three pulses, each allows exactly one advance.
        bus.pc_en = 1'b1;
        for (int i = 0; i < 10; i++) next();
        #3;
        chk("step_idle_pc", int'(bus.pc), 0);
        chk("step_idle_wait", int'(bus.step_wait), 1);
        for (int p = 0; p < 3; p++) begin
            bus.step_exe = 1'b1;
            for (int k = 1; k <= 15; k++) begin
                next();
                if (k == 5) bus.step_exe = 1'b0;
                if (k == 3) begin
                    #3;
                    chk("step_tok_ready", int'(bus.step_wait), 0);
                    chk("step_pc_before", int'(bus.pc), p);
                end
                if (k == 4) begin
                    #3;
                    chk("step_pc_after", int'(bus.pc), p + 1);
                end
            end
        end
        #3 chk("step_total_pc", int'(bus.pc), 3);

        // Reset while a token is pending discards it.
        bus.pc_en = 1'b0; bus.step_exe = 1'b1;
        next(); next();
        bus.step_exe = 1'b0;
        for (int i = 0; i < 5; i++) next();
        #3 chk("tok_pending", int'(bus.step_wait), 0);
        next();
        #3 reset_n = 1'b0;
        #1;
        chk("midstep_rst_pc", int'(bus.pc), 0);
        chk("midstep_rst_wait", int'(bus.step_wait), 1);
        next();
        reset_n = 1'b1; bus.pc_en = 1'b1;
        for (int i = 0; i < 10; i++) next();
        #3 chk("post_rst_pc", int'(bus.pc), 0);
        bus.step_exe = 1'b1;
        next(); next();
        bus.step_exe = 1'b0;
        for (int i = 0; i < 8; i++) next();
        #3 chk("post_rst_step_pc", int'(bus.pc), 1);

        next();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Zimbo core, directly upstream of `control`. It does four things:
- owns the program counter and drives the instruction address;
- captures the instruction word and holds it across two-cycle data accesses on the shared memory port;
- decodes the instruction fields that `control` and the register file consume;
- applies jump/branch redirects and single-step gating.

It also keeps a sticky halt flag and a retired-instruction counter for debug.

## Interface
Parameters:
- PC_W, 8, program counter width; legal range 4..11.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_en  in  1  from control; advance PC this cycle.
- jump  in  1  from control; redirect to absolute target.
- branch  in  1  from control; redirect to PC-relative target.
- insdat  in  1  from control; 0 = memory port returns an instruction, 1 = memory port returns data.
- mem_rdata  in  16  shared memory read data; asynchronous read of the address presented this cycle.
- step_mode  in  1  1 = single-step enabled.
- step_exe  in  1  asynchronous step request; level from debug pin.
- pc  out  PC_W  instruction address (current PC).
- instr  out  16  current instruction word.
- opcode  out  5  instr[15:11].
- rdest  out  3  instr[10:8].
- rsrc1  out  3  instr[7:5].
- rsrc2  out  3  instr[4:2].
- func  out  3  {1'b0, instr[1:0]}.
- rdestBit0  out  1  instr[8].
- halted  out  1  sticky HLT flag.
- step_wait  out  1  step_mode=1 and no step token pending.
- retired  out  16  count of PC advances.

## Operation
Instruction select:
- instr = insdat ? ir_q : mem_rdata (combinational).
- ir_q loads mem_rdata on every edge with insdat=0; holds when insdat=1.

Step gating:
- step_exe passes through a 2-flop synchroniser, then a rising-edge detector (third flop).
- A detected edge sets step_tok.
- step_tok clears on any cycle where advance=1.
- A new edge in the same cycle as a consuming advance keeps step_tok set (set wins).
- advance = pc_en & ~halted & (~step_mode | step_tok).

PC next-state, priority order:
- advance=0: hold.
- advance & jump: pc <= instr[PC_W-1:0].
- advance & branch: pc <= pc + 1 + sext(instr[7:0]), truncated to PC_W.
- advance otherwise: pc <= pc + 1, wrapping at 2^PC_W.
- jump and branch both high: jump wins.

Halt and retire count:
- halted sets on the edge where insdat=0 and instr[15:11]=5'b11111.
- halted clears only on reset; once set, PC and the retired counter freeze.
- retired increments by 1 on every advance and wraps at 16'hFFFF→0.

Decoded fields are taken from instr, so they stay stable through the second cycle of LDA/LDM/STR.

## Timing
- Reset values: pc=0, ir_q=0, halted=0, step_tok=0, synchroniser flops=0, retired=0.
- Decoded outputs after reset follow mem_rdata, because insdat from control is 0 after reset.
- step_wait after reset equals step_mode.
- PC update latency: 1 cycle. The new pc is visible the cycle after advance; the new instr is visible the same cycle through asynchronous memory.
- Two-cycle ops: in cycle 1 (insdat=0, pc_en=0) ir_q captures. In cycle 2 (insdat=1) instr=ir_q and the PC advances if pc_en=1.
- Step latency: a step_exe rising edge produces step_tok 3 clocks later. One advance is then allowed per edge.
- A step edge while pc_en=0 stays pending until pc_en=1; a two-cycle instruction therefore consumes exactly one token.
- Reset asserted mid-instruction returns pc to 0 immediately (asynchronously) and discards ir_q and step_tok.
- Branch offset arithmetic: sign-extend 8 bits to PC_W+8, add, keep the low PC_W bits. Negative offsets wrap modulo 2^PC_W.

## Test plan
- Reset/sequential: PC_W=8, hold pc_en=1 with NOP words for 260 cycles → pc counts 0..255, wraps to 0, then reaches 4; retired=260.
- Jump/branch: at pc=0x10 drive jump with instr=16'hC0_2A → pc=0x2A. At pc=0x05 drive branch with instr[7:0]=8'hF0 → pc=0xF6 (wrap). With jump and branch both high, jump target is taken.
- Two-cycle hold: cycle 1 mem_rdata=16'h1234 (insdat=0, pc_en=0); cycle 2 insdat=1, mem_rdata=16'hBEEF → instr=16'h1234, rdest=3'b010, and pc advances by exactly 1.
- Halt: present 16'hF800 with insdat=0 → halted=1 next cycle; pc and retired are frozen for 20 cycles despite pc_en=1; reset_n low clears halted and pc=0.
- Single-step: step_mode=1, pc_en=1 held → pc static and step_wait=1. Three step_exe pulses, each 5 cycles wide and 10 apart → pc increments exactly 3 times, each 3 clocks after its rising edge.
- Reset mid-step: assert reset_n low while step_tok=1 → step_tok=0, pc=0; after release, pc does not advance until a new step edge.
